branch_predictor_unit: RTL
==========================

# branch_predictor_unit

Parametrised branch predictor and resolver for the five-stage Otter pipeline. In IF it predicts next-PC from a direct-mapped branch target buffer (BTB) and a branch history table (BHT) of saturating counters. In EX it resolves the actual outcome of JAL, JALR and B-type instructions and raises a mispredict redirect. It trains its tables and keeps branch and mispredict statistics. It supersedes the purely combinational EX-stage branch decision.

## Interface
Parameters:
- XLEN, 32, datapath and PC width.
- BHT_ENTRIES, 64, BHT depth; power of two, ≥2.
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2.
- CNT_BITS, 2, counter width, ≥1.

Ports (clock and reset first):
- CLK  in  1  pipeline clock.
- RST_N  in  1  reset; asynchronous, active-low.
- IF_PC  in  XLEN  PC of the instruction in fetch.
- PRED_TAKEN  out  1  predicted taken.
- PRED_TARGET  out  XLEN  predicted next PC.
- EX_VALID  in  1  EX holds a real, non-stalled, non-flushed instruction.
- EX_PC  in  XLEN  PC of the EX instruction.
- EX_IR  in  32  EX instruction word.
- RS1, RS2  in  XLEN  forwarded operands.
- EX_TARGET  in  XLEN  computed jump/branch target for EX_IR.
- EX_PRED_TAKEN  in  1  prediction carried down the pipe with EX_IR.
- EX_PRED_TARGET  in  XLEN  predicted target carried down the pipe with EX_IR.
- PC_SOURCE  out  2  actual next-PC select: 00 PC+4, 01 JALR, 10 branch, 11 JAL.
- MISPREDICT  out  1  flush IF/ID and redirect fetch.
- REDIRECT_PC  out  XLEN  correct next PC when MISPREDICT=1.
- BR_COUNT  out  32  count of resolved control-flow instructions.
- MISS_COUNT  out  32  count of mispredicts.

## Operation
- Indexing:
  - BHT index = PC[log2(BHT_ENTRIES)+1:2].
  - BTB index = PC[log2(BTB_ENTRIES)+1:2].
  - BTB tag = PC[XLEN-1:log2(BTB_ENTRIES)+2].
- BTB entry = {valid, tag, target, is_jump}.
- Lookup:
  - hit = valid && tag match.
  - PRED_TAKEN = hit && (is_jump || BHT counter MSB).
  - PRED_TARGET = PRED_TAKEN ? stored target : IF_PC+4.
- Resolve (only when EX_VALID=1):
  - Opcode 1101111 (JAL) → taken, PC_SOURCE=11.
  - Opcode 1100111 (JALR) → taken, PC_SOURCE=01.
  - Opcode 1100011 → BEQ/BNE/BLT/BGE/BLTU/BGEU per funct3 000/001/100/101/110/111; taken → 10, else 00.
  - Undefined funct3 (010, 011) → not taken, not a control-flow instruction.
  - Any other opcode → 00.
- actual_taken from PC_SOURCE≠00; actual_next = actual_taken ? EX_TARGET : EX_PC+4.
- MISPREDICT = EX_VALID && (actual_taken≠EX_PRED_TAKEN || (actual_taken && EX_TARGET≠EX_PRED_TARGET)).
  - This covers a non-control-flow instruction predicted taken (alias).
- REDIRECT_PC = actual_next.
- Training at the clock edge when EX_VALID=1:
  - Control-flow taken: BTB[idx] ← {1, tag, EX_TARGET, is_jump=(JAL|JALR)}.
  - B-type: BHT counter +1 if taken, −1 if not, saturating at 0 and 2^CNT_BITS−1.
  - Non-control-flow with EX_PRED_TAKEN=1: clear valid of BTB[idx].
  - Not-taken branch: BTB entry is left as is.
- Statistics:
  - BR_COUNT +1 per resolved JAL/JALR/valid B-type.
  - MISS_COUNT +1 per MISPREDICT.
  - Both wrap modulo 2^32.

## Timing
- Lookup and resolve are combinational from registered state; zero-cycle latency.
- Table and statistic updates are visible the cycle after the EX edge.
- Same-cycle IF lookup of an entry being trained sees the old value; there is no bypass.
- With EX_VALID=0: MISPREDICT=0, PC_SOURCE=00, no state change.
- Reset (RST_N low, asynchronous; no table writes while low):
  - All BTB valid bits = 0.
  - All counters = 2^(CNT_BITS−1)−1 (weakly not-taken; 0 when CNT_BITS=1).
  - BR_COUNT = MISS_COUNT = 0.
  - Hence PRED_TAKEN=0 and PRED_TARGET=IF_PC+4.
- Reset asserted mid-operation discards all training immediately.

## Structure
- otter_pkg holds:
  - opcode constants OP_JAL, OP_JALR, OP_BRANCH;
  - funct3 constants;
  - pc_source_t enum {PCS_PLUS4, PCS_JALR, PCS_BRANCH, PCS_JAL};
  - btb_entry_t struct.
- Reuse existing BCG as the single sub-module for BR_EQ/BR_LT/BR_LTU.
- Tables are inline flop arrays.

## Test plan
- Reset: then IF_PC=0x100 → PRED_TAKEN=0, PRED_TARGET=0x104; BR_COUNT=MISS_COUNT=0.
- BNE loop at 0x200, target 0x1F0, RS1≠RS2, resolved 3×:
  - 1st: MISPREDICT=1, REDIRECT_PC=0x1F0.
  - Afterwards IF_PC=0x200 predicts taken to 0x1F0; 2nd and 3rd resolve with MISPREDICT=0.
  - MISS_COUNT=1, BR_COUNT=3.
- Counter saturation (CNT_BITS=2): 5 taken then 1 not-taken → still predicts taken (3→2); a second not-taken → predicts not-taken.
- JALR at 0x300 trained to 0x400, later resolves to 0x500 → MISPREDICT=1, REDIRECT_PC=0x500, PC_SOURCE=01, BTB target becomes 0x500.
- ADD at 0x340 with EX_PRED_TAKEN=1 → MISPREDICT=1, REDIRECT_PC=0x344, BTB entry invalidated; EX_VALID=0 with same inputs → no change.
- RST_N pulsed low mid-loop → prediction for 0x200 returns to not-taken, counts cleared.

Source files
------------

// File: rtl/otter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otter_pkg
//  Description : Shared opcode/funct3 constants and types for the Otter
//                branch predictor and resolver.
//  Revision    : 1.0 - initial release
// ============================================================================
package otter_pkg;

    localparam int PKG_XLEN = 32;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        PCS_PLUS4  = 2'b00,
        PCS_JALR   = 2'b01,
        PCS_BRANCH = 2'b10,
        PCS_JAL    = 2'b11
    } pc_source_t;

    // Tag is held zero-extended to full width so the whole field is compared.
    typedef struct packed {
        logic                valid;
        logic [PKG_XLEN-1:0] tag;
        logic [PKG_XLEN-1:0] target;
        logic                is_jump;
    } btb_entry_t;

endpackage
`default_nettype wire

// File: rtl/branch_predictor_unit_bcg.sv
`default_nettype none
// ============================================================================
//  Module      : BCG
//  Description : Branch condition generator: equality, signed and unsigned
//                less-than of the two forwarded operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module BCG #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] RS1,
    input  logic [XLEN-1:0] RS2,
    output logic            BR_EQ,
    output logic            BR_LT,
    output logic            BR_LTU
);

    assign BR_EQ  = (RS1 == RS2);
    assign BR_LT  = ($signed(RS1) < $signed(RS2));
    assign BR_LTU = (RS1 < RS2);

endmodule
`default_nettype wire

// File: rtl/branch_predictor_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_unit
//  Description : BTB/BHT next-PC predictor in IF plus EX-stage resolver with
//                mispredict redirect, table training and statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_unit
    import otter_pkg::*;
#(
    parameter int XLEN        = PKG_XLEN,
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int CNT_BITS    = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [XLEN-1:0] IF_PC,
    output logic            PRED_TAKEN,
    output logic [XLEN-1:0] PRED_TARGET,
    input  logic            EX_VALID,
    input  logic [XLEN-1:0] EX_PC,
    input  logic [31:0]     EX_IR,
    input  logic [XLEN-1:0] RS1,
    input  logic [XLEN-1:0] RS2,
    input  logic [XLEN-1:0] EX_TARGET,
    input  logic            EX_PRED_TAKEN,
    input  logic [XLEN-1:0] EX_PRED_TARGET,
    output logic [1:0]      PC_SOURCE,
    output logic            MISPREDICT,
    output logic [XLEN-1:0] REDIRECT_PC,
    output logic [31:0]     BR_COUNT,
    output logic [31:0]     MISS_COUNT
);

    localparam int BHT_IW = $clog2(BHT_ENTRIES);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int TAG_W  = XLEN - BTB_IW - 2;

    localparam logic [CNT_BITS-1:0] C_CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0] C_CNT_MAX  = '1;

    btb_entry_t          btb_q [BTB_ENTRIES];
    btb_entry_t          btb_d [BTB_ENTRIES];
    logic [CNT_BITS-1:0] bht_q [BHT_ENTRIES];
    logic [CNT_BITS-1:0] bht_d [BHT_ENTRIES];
    logic [31:0]         br_count_q, br_count_d;
    logic [31:0]         miss_count_q, miss_count_d;

    // ---------------- IF lookup ----------------
    logic [BHT_IW-1:0] w_if_bht_idx;
    logic [BTB_IW-1:0] w_if_btb_idx;
    logic [TAG_W-1:0]  w_if_tag;
    logic              w_if_hit;
    btb_entry_t        w_if_entry;

    assign w_if_bht_idx = IF_PC[BHT_IW+1:2];
    assign w_if_btb_idx = IF_PC[BTB_IW+1:2];
    assign w_if_tag     = IF_PC[XLEN-1:BTB_IW+2];
    assign w_if_entry   = btb_q[w_if_btb_idx];
    assign w_if_hit     = w_if_entry.valid && (w_if_entry.tag == PKG_XLEN'(w_if_tag));

    assign PRED_TAKEN  = w_if_hit && (w_if_entry.is_jump || bht_q[w_if_bht_idx][CNT_BITS-1]);
    assign PRED_TARGET = PRED_TAKEN ? XLEN'(w_if_entry.target) : IF_PC + XLEN'(4);

    // ---------------- EX resolve ----------------
    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic              w_br_eq, w_br_lt, w_br_ltu;
    logic              w_is_branch, w_is_jump, w_cond;
    logic              w_actual_taken;
    pc_source_t        w_pc_source;
    logic [BHT_IW-1:0] w_ex_bht_idx;
    logic [BTB_IW-1:0] w_ex_btb_idx;
    logic [TAG_W-1:0]  w_ex_tag;
    logic              w_unused_ir;

    assign w_opcode     = EX_IR[6:0];
    assign w_funct3     = EX_IR[14:12];
    assign w_ex_bht_idx = EX_PC[BHT_IW+1:2];
    assign w_ex_btb_idx = EX_PC[BTB_IW+1:2];
    assign w_ex_tag     = EX_PC[XLEN-1:BTB_IW+2];
    assign w_unused_ir  = ^{EX_IR[31:15], EX_IR[11:7]};

    BCG #(.XLEN(XLEN)) u_bcg (
        .RS1    (RS1),
        .RS2    (RS2),
        .BR_EQ  (w_br_eq),
        .BR_LT  (w_br_lt),
        .BR_LTU (w_br_ltu)
    );

    always_comb begin
        w_is_branch = 1'b0;
        w_is_jump   = 1'b0;
        w_cond      = 1'b0;
        w_pc_source = PCS_PLUS4;
        if (EX_VALID) begin
            case (w_opcode)
                OP_JAL: begin
                    w_is_jump   = 1'b1;
                    w_pc_source = PCS_JAL;
                end
                OP_JALR: begin
                    w_is_jump   = 1'b1;
                    w_pc_source = PCS_JALR;
                end
                OP_BRANCH: begin
                    w_is_branch = 1'b1;
                    case (w_funct3)
                        F3_BEQ:  w_cond = w_br_eq;
                        F3_BNE:  w_cond = !w_br_eq;
                        F3_BLT:  w_cond = w_br_lt;
                        F3_BGE:  w_cond = !w_br_lt;
                        F3_BLTU: w_cond = w_br_ltu;
                        F3_BGEU: w_cond = !w_br_ltu;
                        default: w_is_branch = 1'b0;
                    endcase
                    if (w_cond) w_pc_source = PCS_BRANCH;
                end
                default: ;
            endcase
        end
    end

    assign w_actual_taken = (w_pc_source != PCS_PLUS4);
    assign PC_SOURCE      = w_pc_source;
    assign REDIRECT_PC    = w_actual_taken ? EX_TARGET : EX_PC + XLEN'(4);
    // A non-control-flow instruction predicted taken lands here via the first term.
    assign MISPREDICT     = EX_VALID && ((w_actual_taken != EX_PRED_TAKEN) ||
                            (w_actual_taken && (EX_TARGET != EX_PRED_TARGET)));

    // ---------------- Training and statistics ----------------
    always_comb begin
        btb_d        = btb_q;
        bht_d        = bht_q;
        br_count_d   = br_count_q;
        miss_count_d = miss_count_q;
        if (EX_VALID) begin
            if (w_actual_taken) begin
                btb_d[w_ex_btb_idx].valid   = 1'b1;
                btb_d[w_ex_btb_idx].tag     = PKG_XLEN'(w_ex_tag);
                btb_d[w_ex_btb_idx].target  = PKG_XLEN'(EX_TARGET);
                btb_d[w_ex_btb_idx].is_jump = w_is_jump;
            end else if (!w_is_branch && !w_is_jump && EX_PRED_TAKEN) begin
                btb_d[w_ex_btb_idx].valid = 1'b0;
            end
            if (w_is_branch) begin
                if (w_cond && (bht_q[w_ex_bht_idx] != C_CNT_MAX))
                    bht_d[w_ex_bht_idx] = bht_q[w_ex_bht_idx] + 1'b1;
                else if (!w_cond && (bht_q[w_ex_bht_idx] != '0))
                    bht_d[w_ex_bht_idx] = bht_q[w_ex_bht_idx] - 1'b1;
            end
            if (w_is_branch || w_is_jump) br_count_d = br_count_q + 32'd1;
            if (MISPREDICT)               miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i] <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= C_CNT_INIT;
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else begin
            btb_q        <= btb_d;
            bht_q        <= bht_d;
            br_count_q   <= br_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign BR_COUNT   = br_count_q;
    assign MISS_COUNT = miss_count_q;

endmodule
`default_nettype wire
